// File: rtl/risc_pkg.sv
// Shared types and constants for the RISC memory responder.
// States, grant IDs and the data word width live here.
package risc_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    GNT_INST,
    GNT_DATA
  } grant_t;

endpackage

// File: rtl/risc_mem_responder_if.sv
// Fetch and data request/ack bundle between the core (master) and the
// memory responder (slave).
interface risc_mem_responder_if
  import risc_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [WORD_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_ack;
  logic [WORD_W-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_rdata, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_rdata, d_ack, d_rdata
  );

endinterface

// File: rtl/risc_mem_array.sv
// Word-addressed 16-bit memory: one synchronous write port and one
// registered read port; read-during-write returns the old word.
module risc_mem_array
  import risc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/risc_mem_responder.sv
// Memory-side responder: arbitrates fetch vs data requests, inserts
// WAIT_CYCLES wait states, and returns a one-cycle ack from the RESP state.
module risc_mem_responder
  import risc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 rst,
  risc_mem_responder_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state;
  state_t            w_state_next;
  grant_t            r_gnt;
  grant_t            w_gnt_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_i_rdata;
  logic [WORD_W-1:0] r_d_rdata;

  logic              w_accept;
  logic              w_gnt_data;
  logic              w_idle;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_we;
  logic              w_cur_we;
  logic              w_enter_resp;
  logic              w_i_ack;
  logic              w_d_ack;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WORD_W-1:0] w_mem_wdata;
  logic [WORD_W-1:0] w_mem_rdata;

  // Data wins unless it also won last time and a fetch is waiting.
  assign w_gnt_data = bus.d_req && !((r_gnt == GNT_DATA) && bus.i_req);
  assign w_gnt_next = w_gnt_data ? GNT_DATA : GNT_INST;
  assign w_sel_addr = w_gnt_data ? bus.d_addr : bus.i_addr;
  assign w_sel_we   = w_gnt_data && bus.d_we;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          w_accept     = 1'b1;
          w_state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // With zero wait states the memory is accessed straight from the live
  // request fields, otherwise from the copy latched at accept.
  assign w_idle       = (r_state == IDLE);
  assign w_mem_addr   = w_idle ? w_sel_addr : r_addr;
  assign w_cur_we     = w_idle ? w_sel_we : r_we;
  assign w_mem_wdata  = w_idle ? bus.d_wdata : r_wdata;
  assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
  assign w_mem_we     = w_enter_resp && w_cur_we && !rst;
  assign w_mem_re     = w_enter_resp && !w_cur_we;

  assign w_i_ack = (r_state == RESP) && (r_gnt == GNT_INST);
  assign w_d_ack = (r_state == RESP) && (r_gnt == GNT_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= GNT_INST;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // r_gnt doubles as the last-grant flag for fairness.
        r_gnt   <= w_gnt_next;
        r_addr  <= w_sel_addr;
        r_we    <= w_sel_we;
        r_wdata <= bus.d_wdata;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_i_ack) begin
        r_i_rdata <= w_mem_rdata;
      end
      if (w_d_ack && !r_we) begin
        r_d_rdata <= w_mem_rdata;
      end
    end
  end

  risc_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_waddr(w_mem_addr),
    .i_wdata(w_mem_wdata),
    .i_re   (w_mem_re),
    .i_raddr(w_mem_addr),
    .o_rdata(w_mem_rdata)
  );

  // Fresh read data is shown in the ack cycle, then held in the port register.
  assign bus.i_ack   = w_i_ack;
  assign bus.d_ack   = w_d_ack;
  assign bus.i_rdata = w_i_ack ? w_mem_rdata : r_i_rdata;
  assign bus.d_rdata = (w_d_ack && !r_we) ? w_mem_rdata : r_d_rdata;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Scoreboard bench for risc_mem_responder: three instances with 0, 1 and 3
// wait states; expected acks are queued at issue and compared at ack.
module tb_risc_mem_responder;

  typedef struct {
    bit          is_data;
    logic [15:0] rdata;
    int          ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q3[$];
  logic [15:0] mdl [0:3][0:255];
  logic [15:0] last_i [0:3];
  logic [15:0] last_d [0:3];

  risc_mem_responder_if #(.ADDR_W(8)) if_w0 ();
  risc_mem_responder_if #(.ADDR_W(8)) if_w1 ();
  risc_mem_responder_if #(.ADDR_W(8)) if_w3 ();

  risc_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut_w0 (.clk(clk), .rst(rst), .bus(if_w0));
  risc_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut_w1 (.clk(clk), .rst(rst), .bus(if_w1));
  risc_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(3)) u_dut_w3 (.clk(clk), .rst(rst), .bus(if_w3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input int d, input logic req, input logic [7:0] addr);
    case (d)
      0: begin if_w0.i_req = req; if_w0.i_addr = addr; end
      1: begin if_w1.i_req = req; if_w1.i_addr = addr; end
      default: begin if_w3.i_req = req; if_w3.i_addr = addr; end
    endcase
  endtask

  task automatic set_d(input int d, input logic req, input logic we, input logic [7:0] addr,
                       input logic [15:0] wdata);
    case (d)
      0: begin if_w0.d_req = req; if_w0.d_we = we; if_w0.d_addr = addr; if_w0.d_wdata = wdata; end
      1: begin if_w1.d_req = req; if_w1.d_we = we; if_w1.d_addr = addr; if_w1.d_wdata = wdata; end
      default: begin if_w3.d_req = req; if_w3.d_we = we; if_w3.d_addr = addr; if_w3.d_wdata = wdata; end
    endcase
  endtask

  task automatic push(input int d, input bit is_data, input logic [15:0] rdata, input int ack_cyc);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    e.ack_cyc = ack_cyc;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic pop(input int d, output exp_t e);
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  task automatic mon(input int d, input logic ia, input logic [15:0] ir,
                     input logic da, input logic [15:0] dr);
    exp_t e;
    if (ia !== 1'b1 && da !== 1'b1) return;
    $display("w%0d cyc=%0d i_ack=%b i_rdata=%h d_ack=%b d_rdata=%h", d, cyc, ia, ir, da, dr);
    chk($sformatf("w%0d_single_ack", d), 32'(ia === 1'b1 && da === 1'b1), 32'd0);
    chk($sformatf("w%0d_ack_expected", d), 32'(qsize(d) > 0), 32'd1);
    if (qsize(d) == 0) return;
    pop(d, e);
    chk($sformatf("w%0d_ack_port", d), 32'(da === 1'b1), 32'(e.is_data));
    chk($sformatf("w%0d_ack_cycle", d), cyc, e.ack_cyc);
    chk($sformatf("w%0d_rdata", d), e.is_data ? {16'd0, dr} : {16'd0, ir}, {16'd0, e.rdata});
  endtask

  always @(negedge clk) begin
    mon(0, if_w0.i_ack, if_w0.i_rdata, if_w0.d_ack, if_w0.d_rdata);
    mon(1, if_w1.i_ack, if_w1.i_rdata, if_w1.d_ack, if_w1.d_rdata);
    mon(3, if_w3.i_ack, if_w3.i_rdata, if_w3.d_ack, if_w3.d_rdata);
  end

  // One transaction on an idle port; returns on the cycle after its ack.
  task automatic txn(input int d, input bit is_data, input bit we, input logic [7:0] addr,
                     input logic [15:0] wdata);
    if (is_data) begin
      set_d(d, 1'b1, we, addr, wdata);
      if (we) begin
        mdl[d][addr] = wdata;
        push(d, 1'b1, last_d[d], cyc + 1 + d);
      end else begin
        last_d[d] = mdl[d][addr];
        push(d, 1'b1, last_d[d], cyc + 1 + d);
      end
    end else begin
      set_i(d, 1'b1, addr);
      last_i[d] = mdl[d][addr];
      push(d, 1'b0, last_i[d], cyc + 1 + d);
    end
    repeat (d + 2) step();
    if (is_data) set_d(d, 1'b0, 1'b0, 8'h00, 16'h0000);
    else set_i(d, 1'b0, 8'h00);
  endtask

  task automatic clear_holds();
    for (int k = 0; k < 4; k++) begin
      last_i[k] = 16'h0000;
      last_d[k] = 16'h0000;
    end
  endtask

  initial begin
    int t;
    clear_holds();
    set_i(0, 1'b0, 8'h00); set_d(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_i(3, 1'b0, 8'h00); set_d(3, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_i(1, 1'b1, 8'h01); set_d(1, 1'b1, 1'b1, 8'h01, 16'h5678);

    // Reset held 3 cycles with both requests pending
    repeat (3) begin
      step();
      chk("rst_i_ack", 32'(if_w1.i_ack), 32'd0);
      chk("rst_d_ack", 32'(if_w1.d_ack), 32'd0);
      chk("rst_i_rdata", {16'd0, if_w1.i_rdata}, 32'd0);
      chk("rst_d_rdata", {16'd0, if_w1.d_rdata}, 32'd0);
    end
    rst = 1'b0;
    t = cyc;
    mdl[1][8'h01] = 16'h5678;
    push(1, 1'b1, 16'h0000, t + 2);
    push(1, 1'b0, 16'h5678, t + 5);
    last_i[1] = 16'h5678;
    repeat (3) step();
    set_d(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) step();
    set_i(1, 1'b0, 8'h00);

    // Store then load, one wait state
    txn(1, 1'b1, 1'b1, 8'h10, 16'hBEEF);
    txn(1, 1'b1, 1'b0, 8'h10, 16'h0000);

    // Contention fairness: last grant made inst first so data wins the first round
    txn(1, 1'b1, 1'b1, 8'h00, 16'h1234);
    txn(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    t = cyc;
    set_i(1, 1'b1, 8'h00);
    set_d(1, 1'b1, 1'b0, 8'h01, 16'h0000);
    push(1, 1'b1, 16'h5678, t + 2);
    push(1, 1'b0, 16'h1234, t + 5);
    push(1, 1'b1, 16'h5678, t + 8);
    push(1, 1'b0, 16'h1234, t + 11);
    last_d[1] = 16'h5678;
    last_i[1] = 16'h1234;
    repeat (9) step();
    set_d(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    repeat (3) step();
    set_i(1, 1'b0, 8'h00);

    // Hold checks
    txn(1, 1'b1, 1'b1, 8'h02, 16'h9999);
    chk("hold_i_after_store", {16'd0, if_w1.i_rdata}, {16'd0, last_i[1]});
    chk("hold_d_after_store", {16'd0, if_w1.d_rdata}, {16'd0, last_d[1]});
    txn(1, 1'b0, 1'b0, 8'h10, 16'h0000);
    chk("hold_d_after_fetch", {16'd0, if_w1.d_rdata}, {16'd0, last_d[1]});

    // Zero wait states: back-to-back fetches every 2 cycles
    txn(0, 1'b1, 1'b1, 8'h22, 16'hA5A5);
    txn(0, 1'b0, 1'b0, 8'h22, 16'h0000);
    txn(0, 1'b0, 1'b0, 8'h22, 16'h0000);

    // Three wait states: reset in the last WAIT cycle aborts the store
    txn(3, 1'b1, 1'b1, 8'h30, 16'h1111);
    set_d(3, 1'b1, 1'b1, 8'h30, 16'hCAFE);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_d(3, 1'b0, 1'b0, 8'h00, 16'h0000);
    clear_holds();
    txn(3, 1'b1, 1'b0, 8'h30, 16'h0000);

    // Reset in the RESP cycle: store has already committed
    t = cyc;
    set_d(3, 1'b1, 1'b1, 8'h30, 16'hCAFE);
    mdl[3][8'h30] = 16'hCAFE;
    push(3, 1'b1, last_d[3], t + 4);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_d(3, 1'b0, 1'b0, 8'h00, 16'h0000);
    clear_holds();
    txn(3, 1'b1, 1'b0, 8'h30, 16'h0000);

    repeat (4) step();
    chk("drain_w0", qsize(0), 32'd0);
    chk("drain_w1", qsize(1), 32'd0);
    chk("drain_w3", qsize(3), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_mem_responder.md
# risc_mem_responder

Memory-side responder for the 16-bit RISC core. Serves the core's instruction-fetch port (read-only) and data port (load/store) from one word-addressed 16-bit memory behind a req/ack handshake. Includes a programmable wait-state counter and fair two-way arbitration. Sits beside the datapath/control pair and is the target end of the fetch and memory-access requests they issue.

## Interface
- ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W words of 16 bits
- WAIT_CYCLES, 1, extra cycles between accept and ack; legal range 0..15

Ports:
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request
- i_addr  in  ADDR_W  fetch word address
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  16  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  16  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  16  load data

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - no request → stay in IDLE.
  - one or both requests → grant one port, latch its addr/we/wdata and the grant ID.
  - go to WAIT if WAIT_CYCLES > 0, else to RESP.
- WAIT: counter loads WAIT_CYCLES−1 on accept and decrements each cycle; at 0, go to RESP.
- RESP:
  - ack of the granted port is high for exactly this cycle.
  - store: memory write commits on the edge entering RESP.
  - load/fetch: rdata is registered on that same edge.
  - RESP always returns to IDLE.
- Arbitration:
  - data has priority over fetch, except when the previous grant was data and i_req is pending; then fetch wins.
  - a last_grant flag is updated on every accept; it resets to "inst", so data wins the first contention.
- Request fields must stay stable from req rise until ack. Inputs are sampled only at accept.
- A requester deasserts req in the cycle after its ack unless it issues a new transaction.
- i_rdata/d_rdata hold their last value until the next read on that port. A store does not change d_rdata.
- The ungranted port only waits: its ack stays 0 and its rdata is unchanged.
- Memory contents are not reset. Reads of never-written words return X in simulation.

## Timing
- Accept cycle T (IDLE, req high) → ack at cycle T+1+WAIT_CYCLES.
- Minimum transaction period is WAIT_CYCLES+2 cycles (RESP → IDLE takes one cycle).
- Reset values: state IDLE, i_ack 0, d_ack 0, i_rdata 0x0000, d_rdata 0x0000, counter 0, last_grant inst.
- rst in any state aborts on the next edge:
  - no ack is issued;
  - a store that has not yet committed (reset before the RESP edge) does not write;
  - a store already committed stays written.
- Simultaneous i_req and d_req in IDLE: exactly one is accepted; the other is accepted at the next IDLE, WAIT_CYCLES+2 cycles later.
- Back-to-back requests from the same port with req held high: accepted again on the IDLE cycle after the ack.
- Address wrap: none. The full ADDR_W range maps 1:1 onto DEPTH.

## Structure
- Shared package risc_pkg holds:
  - WORD_W = 16;
  - the state typedef (IDLE, WAIT, RESP);
  - the grant typedef (GNT_INST, GNT_DATA).
- Sub-module risc_mem_array is the natural split: DEPTH×16 array, one synchronous write port, one synchronous read port, read-during-write returns old data. It is never addressed for a read and a write in the same cycle.
- The responder owns the FSM, arbiter, wait counter and output registers.

## Test plan
- Reset: assert rst 3 cycles with both reqs high → both acks 0 and both rdata 0x0000 throughout; first accept occurs the cycle after rst falls.
- Store then load, WAIT_CYCLES=1:
  - d_we=1, d_addr=0x10, d_wdata=0xBEEF → d_ack at T+2;
  - then load 0x10 → d_rdata=0xBEEF with d_ack at T'+2;
  - i_ack stays 0 throughout.
- Contention fairness:
  - hold both reqs high, i_addr=0x00 (preloaded 0x1234), d_addr=0x01 (preloaded 0x5678);
  - grants must alternate data, inst, data, inst;
  - acks are 3 cycles apart; rdata values match the preloads.
- WAIT_CYCLES=0: fetch from 0x22 (preloaded 0xA5A5) → i_ack 1 cycle after accept with i_rdata=0xA5A5; back-to-back period is 2 cycles.
- WAIT_CYCLES=3, store 0xCAFE to 0x30 with rst pulsed during WAIT → no d_ack, and a later load of 0x30 returns the old contents. Repeat with rst asserted in the RESP cycle → the later load returns 0xCAFE.
- Hold check: after a load returns 0x5678, issue a store to another address → d_rdata stays 0x5678. A fetch does not alter d_rdata.
